// File: rtl/core_types_pkg.sv
// core_types_pkg
//   Shared core-level widths and types used by the branch predictor update path.
//   GH_LENGTH  : global history length carried with every prediction
//   ASID_WIDTH : address-space identifier width
//   gbpt_update_t : one buffered gbpt update {full_PC, GH, ASID, taken}
//   rr_sel_t   : round-robin pointer naming the requester that wins the next tie
package core_types_pkg;

  localparam int GH_LENGTH  = 8;
  localparam int ASID_WIDTH = 9;

  typedef struct packed {
    logic [31:0]           full_PC;
    logic [GH_LENGTH-1:0]  GH;
    logic [ASID_WIDTH-1:0] ASID;
    logic                  taken;
  } gbpt_update_t;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_sel_t;

endpackage

// File: rtl/gbpt_update_fifo.sv
// gbpt_update_fifo
//   Synchronous circular FIFO of gbpt_update_t entries with flush.
//   CLK/nRST   : clock, synchronous active-low reset (clears pointers, count, storage)
//   flush      : empties the FIFO at the next edge; same-cycle push/pop are dropped
//   push/push_data : enqueue request and entry (ignored while full)
//   pop        : dequeue request (ignored while empty)
//   head_data  : entry at the head, always driven, even when empty
//   count/full/empty : occupancy, all derived from registered state
module gbpt_update_fifo
  import core_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   push,
  input  gbpt_update_t           push_data,
  input  logic                   pop,
  output gbpt_update_t           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  gbpt_update_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push_ok;
  logic          pop_ok;

  // full is computed from the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  // Storage is cleared on reset so the head payload reads zero afterwards.
  assign head_data = mem[head];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[tail] <= push_data;
        tail      <= tail + AW'(1);   // DEPTH is a power of 2: wraps naturally
      end
      if (pop_ok) begin
        head <= head + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gbpt_update_ctrl.sv
// gbpt_update_ctrl
//   Funnels two resolved-branch requesters into the gbpt single update0 port.
//   CLK/nRST          : clock, synchronous active-low reset
//   req0_*/req1_*     : requester valid/ready handshake plus {PC, GH, ASID, taken}
//   flush             : drop all buffered updates, suppress same-cycle accept/issue
//   update_enable     : low pauses issue onto update0
//   update0_*         : head-of-buffer update driven to the gbpt
//   update1_correct   : gbpt verdict, one cycle after each update0 issue
//   stat_clear        : zero both statistics counters
//   stat_total/stat_correct : saturating completed / correctly-predicted counts
//   fifo_count        : buffered entries
module gbpt_update_ctrl
  import core_types_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [31:0]                 req0_start_full_PC,
  input  logic [GH_LENGTH-1:0]        req0_GH,
  input  logic [ASID_WIDTH-1:0]       req0_ASID,
  input  logic                        req0_taken,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [31:0]                 req1_start_full_PC,
  input  logic [GH_LENGTH-1:0]        req1_GH,
  input  logic [ASID_WIDTH-1:0]       req1_ASID,
  input  logic                        req1_taken,
  input  logic                        flush,
  input  logic                        update_enable,
  output logic                        update0_valid,
  output logic [31:0]                 update0_start_full_PC,
  output logic [GH_LENGTH-1:0]        update0_GH,
  output logic [ASID_WIDTH-1:0]       update0_ASID,
  output logic                        update0_taken,
  input  logic                        update1_correct,
  input  logic                        stat_clear,
  output logic [COUNT_WIDTH-1:0]      stat_total,
  output logic [COUNT_WIDTH-1:0]      stat_correct,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  rr_sel_t      rr;
  logic         both_valid;
  logic         grant0;
  logic         grant1;
  logic         full;
  logic         empty;
  logic         push;
  logic         issued_d1;
  gbpt_update_t push_data;
  gbpt_update_t head_data;

  // A lone requester always wins; a tie goes to the requester rr names.
  assign both_valid = req0_valid & req1_valid;
  assign grant0     = req0_valid & (~req1_valid | (rr == RR_REQ0));
  assign grant1     = req1_valid & (~req0_valid | (rr == RR_REQ1));

  // Nothing is accepted or issued while reset is held, so a reset cycle
  // can neither enqueue nor launch an update that would later be lost.
  assign req0_ready = grant0 & ~full & ~flush & nRST;
  assign req1_ready = grant1 & ~full & ~flush & nRST;
  assign push       = req0_ready | req1_ready;

  always_comb begin
    push_data = '0;
    if (req1_ready) begin
      push_data.full_PC = req1_start_full_PC;
      push_data.GH      = req1_GH;
      push_data.ASID    = req1_ASID;
      push_data.taken   = req1_taken;
    end else begin
      push_data.full_PC = req0_start_full_PC;
      push_data.GH      = req0_GH;
      push_data.ASID    = req0_ASID;
      push_data.taken   = req0_taken;
    end
  end

  gbpt_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (update0_valid),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign update0_valid         = ~empty & update_enable & ~flush & nRST;
  assign update0_start_full_PC = head_data.full_PC;
  assign update0_GH            = head_data.GH;
  assign update0_ASID          = head_data.ASID;
  assign update0_taken         = head_data.taken;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr           <= RR_REQ0;
      issued_d1    <= 1'b0;
      stat_total   <= '0;
      stat_correct <= '0;
    end else begin
      // Completion tracking is independent of flush: an update already on
      // update0 last cycle still gets its verdict counted.
      issued_d1 <= update0_valid;

      // The pointer only moves when a tie is actually resolved by an accept.
      if (both_valid && push) begin
        rr <= req0_ready ? RR_REQ1 : RR_REQ0;
      end

      if (stat_clear) begin
        stat_total   <= '0;
        stat_correct <= '0;
      end else if (issued_d1) begin
        if (stat_total != '1) begin
          stat_total <= stat_total + COUNT_WIDTH'(1);
        end
        if (update1_correct && (stat_correct != '1)) begin
          stat_correct <= stat_correct + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gbpt_update_ctrl.sv
// tb_gbpt_update_ctrl
//   Self-checking bench: a directed vector table from reset, hand-written
//   multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_gbpt_update_ctrl;
  import core_types_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int MAXC  = (1 << CW) - 1;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic                  req0_valid, req1_valid;
  logic                  req0_ready, req1_ready;
  logic [31:0]           req0_start_full_PC, req1_start_full_PC;
  logic [GH_LENGTH-1:0]  req0_GH, req1_GH;
  logic [ASID_WIDTH-1:0] req0_ASID, req1_ASID;
  logic                  req0_taken, req1_taken;
  logic                  flush, update_enable;
  logic                  update0_valid;
  logic [31:0]           update0_start_full_PC;
  logic [GH_LENGTH-1:0]  update0_GH;
  logic [ASID_WIDTH-1:0] update0_ASID;
  logic                  update0_taken;
  logic                  update1_correct, stat_clear;
  logic [CW-1:0]         stat_total, stat_correct;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 CLK = ~CLK;

  gbpt_update_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .COUNT_WIDTH (CW)
  ) dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .req0_valid            (req0_valid),
    .req0_ready            (req0_ready),
    .req0_start_full_PC    (req0_start_full_PC),
    .req0_GH               (req0_GH),
    .req0_ASID             (req0_ASID),
    .req0_taken            (req0_taken),
    .req1_valid            (req1_valid),
    .req1_ready            (req1_ready),
    .req1_start_full_PC    (req1_start_full_PC),
    .req1_GH               (req1_GH),
    .req1_ASID             (req1_ASID),
    .req1_taken            (req1_taken),
    .flush                 (flush),
    .update_enable         (update_enable),
    .update0_valid         (update0_valid),
    .update0_start_full_PC (update0_start_full_PC),
    .update0_GH            (update0_GH),
    .update0_ASID          (update0_ASID),
    .update0_taken         (update0_taken),
    .update1_correct       (update1_correct),
    .stat_clear            (stat_clear),
    .stat_total            (stat_total),
    .stat_correct          (stat_correct),
    .fifo_count            (fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered updates as a plain queue, counters as ints.
  gbpt_update_t mq[$];
  int           m_rr;
  bit           m_issued;
  int           m_tot, m_cor;

  // Values seen in the most recent step, for the hand-written sequences.
  logic          s_r0, s_r1, s_uv;
  logic [31:0]   s_pc;
  logic [$clog2(DEPTH):0] s_count;
  logic [CW-1:0] s_tot, s_cor;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_start_full_PC = '0; req1_start_full_PC = '0;
    req0_GH = '0; req1_GH = '0; req0_ASID = '0; req1_ASID = '0;
    req0_taken = 0; req1_taken = 0;
    flush = 0; update_enable = 0; update1_correct = 0; stat_clear = 0;
  endtask

  // Reset without checking; resynchronises the model with the DUT.
  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    @(posedge CLK);
    mq.delete(); m_rr = 0; m_issued = 0; m_tot = 0; m_cor = 0;
    @(negedge CLK);
    nRST = 1;
  endtask

  // One clock: check all outputs against the model, then advance the model.
  task automatic step();
    int           g;
    bit           fe, e0, e1, ev;
    gbpt_update_t ent;
    #1;
    fe = (mq.size() >= DEPTH);
    g  = -1;
    if (req0_valid && req1_valid) g = m_rr;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    e0 = nRST && !flush && !fe && (g == 0);
    e1 = nRST && !flush && !fe && (g == 1);
    ev = nRST && !flush && update_enable && (mq.size() > 0);
    s_r0 = req0_ready; s_r1 = req1_ready; s_uv = update0_valid;
    s_pc = update0_start_full_PC; s_count = fifo_count;
    s_tot = stat_total; s_cor = stat_correct;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("update0_valid", update0_valid, ev);
    if (mq.size() > 0) begin
      chk("update0_PC", update0_start_full_PC, mq[0].full_PC);
      chk("update0_GH", update0_GH, mq[0].GH);
      chk("update0_ASID", update0_ASID, mq[0].ASID);
      chk("update0_taken", update0_taken, mq[0].taken);
    end
    chk("fifo_count", fifo_count, mq.size());
    chk("stat_total", stat_total, m_tot);
    chk("stat_correct", stat_correct, m_cor);
    @(posedge CLK);
    if (!nRST) begin
      mq.delete(); m_rr = 0; m_issued = 0; m_tot = 0; m_cor = 0;
    end else begin
      if (stat_clear) begin
        m_tot = 0; m_cor = 0;
      end else if (m_issued) begin
        if (m_tot < MAXC) m_tot++;
        if (update1_correct && m_cor < MAXC) m_cor++;
      end
      m_issued = ev;
      if (flush) begin
        mq.delete();
      end else begin
        if (ev) void'(mq.pop_front());
        if (e0 || e1) begin
          ent.full_PC = e0 ? req0_start_full_PC : req1_start_full_PC;
          ent.GH      = e0 ? req0_GH : req1_GH;
          ent.ASID    = e0 ? req0_ASID : req1_ASID;
          ent.taken   = e0 ? req0_taken : req1_taken;
          mq.push_back(ent);
          if (req0_valid && req1_valid) m_rr = e0 ? 1 : 0;
        end
      end
    end
    @(negedge CLK);
  endtask

  typedef struct {
    bit          r0v;
    logic [31:0] r0pc;
    bit          r0t;
    bit          r1v;
    logic [31:0] r1pc;
    bit          en;
    bit          cor;
    bit          clr;
    bit          x_r0;
    bit          x_r1;
    bit          x_uv;
    logic [31:0] x_pc;
    int          x_cnt;
    int          x_tot;
    int          x_cor;
  } vec_t;

  vec_t tv[14];

  initial begin
    // r0v r0pc r0t r1v r1pc en cor clr | x_r0 x_r1 x_uv x_pc x_cnt x_tot x_cor
    tv[0]  = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 0, 32'h0,    0, 0, 0};
    tv[1]  = '{1, 32'h1000, 1, 0, 32'h0,    1, 0, 0,  1, 0, 0, 32'h0,    0, 0, 0};
    tv[2]  = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 1, 32'h1000, 1, 0, 0};
    tv[3]  = '{0, 32'h0,    0, 0, 32'h0,    1, 1, 0,  0, 0, 0, 32'h0,    0, 0, 0};
    tv[4]  = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 0, 32'h0,    0, 1, 1};
    tv[5]  = '{0, 32'h0,    0, 1, 32'h2000, 1, 0, 1,  0, 1, 0, 32'h0,    0, 1, 1};
    tv[6]  = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 1, 32'h2000, 1, 0, 0};
    tv[7]  = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 0, 32'h0,    0, 0, 0};
    tv[8]  = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 0, 32'h0,    0, 1, 0};
    tv[9]  = '{1, 32'h3000, 0, 1, 32'h4000, 1, 0, 0,  1, 0, 0, 32'h0,    0, 1, 0};
    tv[10] = '{1, 32'h3000, 0, 1, 32'h4000, 1, 0, 0,  0, 1, 1, 32'h3000, 1, 1, 0};
    tv[11] = '{0, 32'h0,    0, 0, 32'h0,    1, 1, 0,  0, 0, 1, 32'h4000, 1, 1, 0};
    tv[12] = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 0, 32'h1000, 0, 2, 1};
    tv[13] = '{0, 32'h0,    0, 0, 32'h0,    1, 0, 0,  0, 0, 0, 32'h1000, 0, 3, 1};

    idle_inputs();
    nRST = 0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;

    // Directed vectors from reset: single update latency, clear, tie-break, wrap.
    for (int i = 0; i < 14; i++) begin
      req0_valid = tv[i].r0v; req0_start_full_PC = tv[i].r0pc; req0_taken = tv[i].r0t;
      req1_valid = tv[i].r1v; req1_start_full_PC = tv[i].r1pc;
      update_enable = tv[i].en; update1_correct = tv[i].cor; stat_clear = tv[i].clr;
      #1;
      chk("vec_req0_ready", req0_ready, tv[i].x_r0);
      chk("vec_req1_ready", req1_ready, tv[i].x_r1);
      chk("vec_update0_valid", update0_valid, tv[i].x_uv);
      chk("vec_update0_PC", update0_start_full_PC, tv[i].x_pc);
      chk("vec_fifo_count", fifo_count, tv[i].x_cnt);
      chk("vec_stat_total", stat_total, tv[i].x_tot);
      chk("vec_stat_correct", stat_correct, tv[i].x_cor);
      @(posedge CLK);
      @(negedge CLK);
    end

    // Contention from reset: grants alternate 0,1,0,1,...
    do_reset();
    update_enable = 1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1; req0_start_full_PC = 32'h100 + i;
      req1_valid = 1; req1_start_full_PC = 32'h200 + i;
      step();
      chk("contention_grant0", s_r0, (i % 2) == 0);
      chk("contention_grant1", s_r1, (i % 2) == 1);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (2) step();

    // Backpressure with pointers mid-ring, then drain in order across the wrap.
    update_enable = 0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1; req0_start_full_PC = 32'h5000 + i;
      step();
      chk("full_accept", s_r0, i < 4);
    end
    req0_valid = 0;
    chk("full_count", fifo_count, 4);
    update_enable = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_valid", s_uv, 1);
      chk("drain_order", s_pc, 32'h5000 + i);
    end
    step();
    chk("drain_done", s_uv, 0);

    // Flush right after an issue: buffer empties, the issue still counts.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_start_full_PC = 32'h6000 + i;
      step();
    end
    req0_valid = 0;
    update_enable = 1;
    step();
    chk("flush_issue_t", s_uv, 1);
    flush = 1;
    step();
    chk("flush_no_issue_t1", s_uv, 0);
    flush = 0;
    step();
    chk("flush_no_issue_t2", s_uv, 0);
    chk("flush_count_t2", s_count, 0);
    chk("flush_total_t2", s_tot, 1);

    // Saturation, then clear colliding with a completion.
    do_reset();
    req0_valid = 1; req0_start_full_PC = 32'h7000;
    update_enable = 1; update1_correct = 1;
    repeat (MAXC + 4) step();
    chk("sat_total", s_tot, MAXC);
    chk("sat_correct", s_cor, MAXC);
    stat_clear = 1;
    step();
    stat_clear = 0;
    step();
    chk("clear_total", s_tot, 0);
    chk("clear_correct", s_cor, 0);

    // Reset mid-stream with two buffered entries.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1; req0_start_full_PC = 32'h8000 + i;
      step();
    end
    req0_valid = 0;
    update_enable = 1;
    nRST = 0;
    step();
    nRST = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_issue", s_uv, 0);
      chk("rst_payload", s_pc, 0);
      chk("rst_count", s_count, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_start_full_PC = $urandom; req1_start_full_PC = $urandom;
      req0_GH = GH_LENGTH'($urandom); req1_GH = GH_LENGTH'($urandom);
      req0_ASID = ASID_WIDTH'($urandom); req1_ASID = ASID_WIDTH'($urandom);
      req0_taken = ($urandom_range(0, 1) == 1); req1_taken = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 19) == 0);
      update_enable = ($urandom_range(0, 9) < 6);
      update1_correct = ($urandom_range(0, 1) == 1);
      stat_clear = ($urandom_range(0, 39) == 0);
      nRST = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
